// File: rtl/time_counter_if.sv
// -----------------------------------------------------------------------------
// time_counter_if
//
// Purpose:
//   Bundles the signals between the tick generator / edit logic (master) and
//   the calendar counter (slave). clk and rst are not part of the bundle.
//
// Signals:
//   tick       advance-one-second strobe, one clk cycle wide
//   load       synchronous load of all ld_* fields (beats tick)
//   ld_sec     seconds to load            (6 bits)
//   ld_min     minutes to load            (6 bits)
//   ld_hour    hours to load              (5 bits)
//   ld_day     day of month to load       (5 bits)
//   ld_mon     month to load              (4 bits)
//   ld_year    year in century to load    (7 bits)
//   ld_cent    century to load            (7 bits)
//   sec, min   current seconds / minutes, 0..59
//   hour       current hour, 0..23
//   day        current day of month, 1..31
//   mon        current month, 1..12
//   year, cent current year in century / century, 0..99
//   leap       current year is a leap year (combinational)
//   new_day    one-cycle pulse on midnight rollover
//   cent_wrap  one-cycle pulse when the century wraps 99 -> 0
// -----------------------------------------------------------------------------
interface time_counter_if;
  logic       tick;
  logic       load;
  logic [5:0] ld_sec;
  logic [5:0] ld_min;
  logic [4:0] ld_hour;
  logic [4:0] ld_day;
  logic [3:0] ld_mon;
  logic [6:0] ld_year;
  logic [6:0] ld_cent;

  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [4:0] day;
  logic [3:0] mon;
  logic [6:0] year;
  logic [6:0] cent;
  logic       leap;
  logic       new_day;
  logic       cent_wrap;

  modport master (
    output tick, load,
    output ld_sec, ld_min, ld_hour, ld_day, ld_mon, ld_year, ld_cent,
    input  sec, min, hour, day, mon, year, cent,
    input  leap, new_day, cent_wrap
  );

  modport slave (
    input  tick, load,
    input  ld_sec, ld_min, ld_hour, ld_day, ld_mon, ld_year, ld_cent,
    output sec, min, hour, day, mon, year, cent,
    output leap, new_day, cent_wrap
  );
endinterface

// File: rtl/time_counter.sv
// -----------------------------------------------------------------------------
// time_counter
//
// Purpose:
//   Calendar / time-of-day counter. Each tick advances seconds and carries
//   through minutes, hours, day, month, year and century in a single cycle.
//   Month lengths are exact and leap years follow the Gregorian rule across
//   the full century count. A synchronous load sets every field at once,
//   with out-of-range values clamped to the nearest legal value.
//
// Parameters:
//   RST_CENT   century after reset (0..99)
//   RST_YEAR   year in century after reset (0..99)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   tc         time_counter_if slave modport (tick/load/ld_* in, time out)
// -----------------------------------------------------------------------------
module time_counter #(
  parameter logic [6:0] RST_CENT = 7'd20,
  parameter logic [6:0] RST_YEAR = 7'd0
) (
  input  logic           clk,
  input  logic           rst,
  time_counter_if.slave  tc
);

  // ---------------------------------------------------------------------------
  // Calendar helpers
  // ---------------------------------------------------------------------------

  // Divisible-by-4 checks only need the two low bits. Year 00 of a century is
  // a leap year only when the century itself is divisible by 4 (2000 yes,
  // 1900/2100 no), which is the /400 part of the Gregorian rule.
  function automatic logic is_leap(input logic [6:0] y, input logic [6:0] c);
    return (y[1:0] == 2'b00) && ((y != 7'd0) || (c[1:0] == 2'b00));
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m,
                                           input logic       lp);
    logic [4:0] len;
    case (m)
      4'd2:    len = lp ? 5'd29 : 5'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   len = 5'd30;
      default: len = 5'd31;
    endcase
    return len;
  endfunction

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [5:0] sec_q,  sec_d;
  logic [5:0] min_q,  min_d;
  logic [4:0] hour_q, hour_d;
  logic [4:0] day_q,  day_d;
  logic [3:0] mon_q,  mon_d;
  logic [6:0] year_q, year_d;
  logic [6:0] cent_q, cent_d;
  logic       new_day_q,   new_day_d;
  logic       cent_wrap_q, cent_wrap_d;

  // ---------------------------------------------------------------------------
  // Current-date decode
  // ---------------------------------------------------------------------------
  logic       leap_cur;
  logic [4:0] len_cur;

  assign leap_cur = is_leap(year_q, cent_q);
  assign len_cur  = month_len(mon_q, leap_cur);

  // ---------------------------------------------------------------------------
  // Load sanitisation
  // ---------------------------------------------------------------------------
  logic [5:0] ld_sec_s;
  logic [5:0] ld_min_s;
  logic [4:0] ld_hour_s;
  logic [3:0] ld_mon_s;
  logic [6:0] ld_year_s;
  logic [6:0] ld_cent_s;
  logic [4:0] ld_len;
  logic [4:0] ld_day_s;

  always_comb begin
    ld_sec_s  = (tc.ld_sec  > 6'd59) ? 6'd59 : tc.ld_sec;
    ld_min_s  = (tc.ld_min  > 6'd59) ? 6'd59 : tc.ld_min;
    ld_hour_s = (tc.ld_hour > 5'd23) ? 5'd23 : tc.ld_hour;
    ld_year_s = (tc.ld_year > 7'd99) ? 7'd99 : tc.ld_year;
    ld_cent_s = (tc.ld_cent > 7'd99) ? 7'd99 : tc.ld_cent;

    if (tc.ld_mon == 4'd0) begin
      ld_mon_s = 4'd1;
    end else if (tc.ld_mon > 4'd12) begin
      ld_mon_s = 4'd12;
    end else begin
      ld_mon_s = tc.ld_mon;
    end

    // Day clamp must use the already-clamped month/year/century, otherwise a
    // bogus month would pick the wrong length.
    ld_len = month_len(ld_mon_s, is_leap(ld_year_s, ld_cent_s));

    if (tc.ld_day == 5'd0) begin
      ld_day_s = 5'd1;
    end else if (tc.ld_day > ld_len) begin
      ld_day_s = ld_len;
    end else begin
      ld_day_s = tc.ld_day;
    end
  end

  // ---------------------------------------------------------------------------
  // Carry chain
  //   Each carry is "this field wraps on this tick". Comparisons use >= so a
  //   field that somehow sits out of range still wraps rather than running on.
  // ---------------------------------------------------------------------------
  logic carry_min;
  logic carry_hour;
  logic carry_day;
  logic carry_mon;
  logic carry_year;
  logic carry_cent;
  logic wrap_cent;

  always_comb begin
    carry_min  = 1'b0;
    carry_hour = 1'b0;
    carry_day  = 1'b0;
    carry_mon  = 1'b0;
    carry_year = 1'b0;
    carry_cent = 1'b0;
    wrap_cent  = 1'b0;
    if (tc.tick) begin
      carry_min  = (sec_q >= 6'd59);
      carry_hour = carry_min  && (min_q  >= 6'd59);
      carry_day  = carry_hour && (hour_q >= 5'd23);
      carry_mon  = carry_day  && (day_q  >= len_cur);
      carry_year = carry_mon  && (mon_q  >= 4'd12);
      carry_cent = carry_year && (year_q >= 7'd99);
      wrap_cent  = carry_cent && (cent_q >= 7'd99);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    day_d       = day_q;
    mon_d       = mon_q;
    year_d      = year_q;
    cent_d      = cent_q;
    new_day_d   = 1'b0;
    cent_wrap_d = 1'b0;

    if (tc.load) begin
      // A simultaneous tick is dropped and loads never raise the pulses.
      sec_d  = ld_sec_s;
      min_d  = ld_min_s;
      hour_d = ld_hour_s;
      day_d  = ld_day_s;
      mon_d  = ld_mon_s;
      year_d = ld_year_s;
      cent_d = ld_cent_s;
    end else if (tc.tick) begin
      sec_d = carry_min ? 6'd0 : sec_q + 6'd1;
      if (carry_min) begin
        min_d = carry_hour ? 6'd0 : min_q + 6'd1;
      end
      if (carry_hour) begin
        hour_d = carry_day ? 5'd0 : hour_q + 5'd1;
      end
      if (carry_day) begin
        day_d = carry_mon ? 5'd1 : day_q + 5'd1;
      end
      if (carry_mon) begin
        mon_d = carry_year ? 4'd1 : mon_q + 4'd1;
      end
      if (carry_year) begin
        year_d = carry_cent ? 7'd0 : year_q + 7'd1;
      end
      if (carry_cent) begin
        cent_d = wrap_cent ? 7'd0 : cent_q + 7'd1;
      end
      new_day_d   = carry_day;
      cent_wrap_d = wrap_cent;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= 5'd0;
      day_q       <= 5'd1;
      mon_q       <= 4'd1;
      year_q      <= RST_YEAR;
      cent_q      <= RST_CENT;
      new_day_q   <= 1'b0;
      cent_wrap_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      mon_q       <= mon_d;
      year_q      <= year_d;
      cent_q      <= cent_d;
      new_day_q   <= new_day_d;
      cent_wrap_q <= cent_wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tc.sec       = sec_q;
  assign tc.min       = min_q;
  assign tc.hour      = hour_q;
  assign tc.day       = day_q;
  assign tc.mon       = mon_q;
  assign tc.year      = year_q;
  assign tc.cent      = cent_q;
  assign tc.leap      = leap_cur;
  assign tc.new_day   = new_day_q;
  assign tc.cent_wrap = cent_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// -----------------------------------------------------------------------------
// tb_time_counter
//
// Purpose:
//   Self-checking bench for time_counter. A behavioural calendar model keeps
//   the expected date/time in plain integers; every driven cycle pushes the
//   model's packed expectation into a queue, which is popped and compared
//   against the DUT one clock edge later.
// -----------------------------------------------------------------------------
module tb_time_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  time_counter_if tc ();

  time_counter #(
    .RST_CENT (7'd20),
    .RST_YEAR (7'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tc  (tc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int m_sec, m_min, m_hour, m_day, m_mon, m_year, m_cent;
  bit m_nd, m_cw;

  logic [42:0] exp_q[$];
  logic [42:0] exp_v;
  logic [42:0] obs_v;

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  function automatic bit gleap(input int full_year);
    return (full_year % 4 == 0) && ((full_year % 100 != 0) || (full_year % 400 == 0));
  endfunction

  function automatic int mdays(input int mo, input int full_year);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo == 2 && gleap(full_year)) return 29;
    return t[mo-1];
  endfunction

  function automatic logic [42:0] pack_model();
    return {6'(m_sec), 6'(m_min), 5'(m_hour), 5'(m_day), 4'(m_mon),
            7'(m_year), 7'(m_cent), gleap(m_cent * 100 + m_year), m_nd, m_cw};
  endfunction

  function automatic logic [42:0] observe();
    return {tc.sec, tc.min, tc.hour, tc.day, tc.mon, tc.year, tc.cent,
            tc.leap, tc.new_day, tc.cent_wrap};
  endfunction

  function automatic string fmt(input logic [42:0] v);
    return $sformatf("%0d:%0d:%0d d%0d m%0d y%0d c%0d leap%0b nd%0b cw%0b",
                     v[42:37], v[36:31], v[30:26], v[25:21], v[20:17],
                     v[16:10], v[9:3], v[2], v[1], v[0]);
  endfunction

  function automatic void model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1;
    m_year = 0; m_cent = 20; m_nd = 0; m_cw = 0;
  endfunction

  function automatic void model_tick();
    m_nd = 0; m_cw = 0;
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0; m_min++;
      if (m_min == 60) begin
        m_min = 0; m_hour++;
        if (m_hour == 24) begin
          m_hour = 0; m_nd = 1; m_day++;
          if (m_day > mdays(m_mon, m_cent * 100 + m_year)) begin
            m_day = 1; m_mon++;
            if (m_mon == 13) begin
              m_mon = 1; m_year++;
              if (m_year == 100) begin
                m_year = 0; m_cent++;
                if (m_cent == 100) begin
                  m_cent = 0; m_cw = 1;
                end
              end
            end
          end
        end
      end
    end
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_load(input int s, input int mi, input int h,
                                     input int d, input int mo, input int y,
                                     input int c);
    m_sec  = clampi(s, 0, 59);
    m_min  = clampi(mi, 0, 59);
    m_hour = clampi(h, 0, 23);
    m_mon  = clampi(mo, 1, 12);
    m_year = clampi(y, 0, 99);
    m_cent = clampi(c, 0, 99);
    m_day  = clampi(d, 1, mdays(m_mon, m_cent * 100 + m_year));
    m_nd = 0; m_cw = 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers (stimulus + scoreboard push only)
  // ---------------------------------------------------------------------------
  task automatic drive_tick();
    tc.load = 1'b0;
    tc.tick = 1'b1;
    model_tick();
    exp_q.push_back(pack_model());
  endtask

  task automatic drive_idle();
    tc.load = 1'b0;
    tc.tick = 1'b0;
    m_nd = 0; m_cw = 0;
    exp_q.push_back(pack_model());
  endtask

  task automatic drive_load(input int s, input int mi, input int h, input int d,
                            input int mo, input int y, input int c,
                            input bit with_tick);
    tc.ld_sec  = 6'(s);
    tc.ld_min  = 6'(mi);
    tc.ld_hour = 5'(h);
    tc.ld_day  = 5'(d);
    tc.ld_mon  = 4'(mo);
    tc.ld_year = 7'(y);
    tc.ld_cent = 7'(c);
    tc.load    = 1'b1;
    tc.tick    = with_tick;
    model_load(s, mi, h, d, mo, y, c);
    exp_q.push_back(pack_model());
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    tc.load = 1'b0; tc.tick = 1'b0;
    tc.ld_sec = '0; tc.ld_min = '0; tc.ld_hour = '0; tc.ld_day = '0;
    tc.ld_mon = '0; tc.ld_year = '0; tc.ld_cent = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tc.tick = i[0];
      exp_q.push_back(pack_model());
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got %s want %s", i, fmt(obs_v), fmt(exp_v));
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_tick();
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset_tick[%0d]: got %s want %s", i, fmt(obs_v), fmt(exp_v));
      end
    end
    n_cmp++;
    if (tc.sec !== 6'd3) begin
      n_bad++;
      $display("FAIL reset_sec3: got %0d want 3", tc.sec);
    end
  endtask

  task automatic test_midnight();
    drive_load(59, 59, 23, 31, 1, 23, 20, 1'b0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL midnight_load: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    drive_tick();
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL midnight_tick: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    n_cmp++;
    if ({tc.hour, tc.day, tc.mon, tc.new_day} !== {5'd0, 5'd1, 4'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL midnight_feb1: got h%0d d%0d m%0d nd%0b want h0 d1 m2 nd1",
               tc.hour, tc.day, tc.mon, tc.new_day);
    end
    drive_idle();
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL midnight_pulse_end: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
  endtask

  task automatic test_leap();
    int yr[3]   = '{24, 0, 0};
    int ce[3]   = '{20, 21, 20};
    int dreq[3] = '{29, 1, 29};
    int mreq[3] = '{2, 3, 2};
    for (int i = 0; i < 3; i++) begin
      drive_load(59, 59, 23, 28, 2, yr[i], ce[i], 1'b0);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL leap_load[%0d]: got %s want %s", i, fmt(obs_v), fmt(exp_v));
      end
      drive_tick();
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL leap_tick[%0d]: got %s want %s", i, fmt(obs_v), fmt(exp_v));
      end
      n_cmp++;
      if (tc.day !== 5'(dreq[i]) || tc.mon !== 4'(mreq[i])) begin
        n_bad++;
        $display("FAIL leap_date[%0d]: got d%0d m%0d want d%0d m%0d",
                 i, tc.day, tc.mon, dreq[i], mreq[i]);
      end
    end
  endtask

  task automatic test_cent_wrap();
    drive_load(59, 59, 23, 31, 12, 99, 99, 1'b0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL cwrap_load: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    drive_tick();
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL cwrap_tick: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    n_cmp++;
    if ({tc.year, tc.cent, tc.cent_wrap} !== {7'd0, 7'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL cwrap_fields: got y%0d c%0d cw%0b want y0 c0 cw1",
               tc.year, tc.cent, tc.cent_wrap);
    end
    drive_idle();
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL cwrap_pulse_end: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
  endtask

  task automatic test_sanitise();
    // sec, min, hour, day, mon, year, cent
    int v[6][7] = '{
      '{63,  0, 30, 31,  0,  23,  20},
      '{ 0,  0,  0, 31,  4,  23,  20},
      '{10, 60, 12,  0, 15, 120, 127},
      '{ 5,  5,  5, 31,  2,  24,  20},
      '{ 5,  5,  5, 30,  2,  23,  20},
      '{ 5,  5,  5, 29,  2,   0,  19}
    };
    for (int i = 0; i < 6; i++) begin
      drive_load(v[i][0], v[i][1], v[i][2], v[i][3], v[i][4], v[i][5], v[i][6], 1'b0);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL sanitise[%0d]: got %s want %s", i, fmt(obs_v), fmt(exp_v));
      end
    end
    drive_load(63, 0, 30, 31, 0, 23, 20, 1'b0);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    n_cmp++;
    if ({tc.sec, tc.hour, tc.mon, tc.day} !== {6'd59, 5'd23, 4'd1, 5'd31}) begin
      n_bad++;
      $display("FAIL sanitise_fixed: got s%0d h%0d m%0d d%0d want s59 h23 m1 d31",
               tc.sec, tc.hour, tc.mon, tc.day);
    end
  endtask

  task automatic test_priority();
    drive_load(59, 59, 23, 31, 12, 99, 99, 1'b1);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL priority_load_tick: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    drive_load(7, 8, 9, 10, 11, 12, 13, 1'b1);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL priority_plain: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
  endtask

  task automatic test_back_to_back();
    drive_load(55, 59, 0, 15, 6, 23, 20, 1'b0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL b2b_load: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    for (int i = 0; i < 8; i++) begin
      drive_tick();
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_tick[%0d]: got %s want %s", i, fmt(obs_v), fmt(exp_v));
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive_idle();
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL b2b_idle[%0d]: got %s want %s", i, fmt(obs_v), fmt(exp_v));
      end
    end
  endtask

  task automatic test_async_reset();
    time t_rst;
    drive_load(56, 34, 12, 5, 7, 23, 20, 1'b0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL areset_load: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    tc.load = 1'b0;
    tc.tick = 1'b1;
    #3;
    t_rst = $time;
    rst = 1'b0;
    model_reset();
    #1;
    exp_v = pack_model(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL areset_immediate: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    @(posedge clk);
    n_cmp++;
    if ($time - t_rst < 2) begin
      n_bad++;
      $display("FAIL areset_timing: reset applied %0t before edge, want >= 2", $time - t_rst);
    end
    #1;
    exp_q.push_back(pack_model());
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL areset_hold: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    rst = 1'b1;
    drive_tick();
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL areset_first_tick: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
    drive_idle();
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs_v = observe(); n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL areset_idle: got %s want %s", fmt(obs_v), fmt(exp_v));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_midnight();
    test_leap();
    test_cent_wrap();
    test_sanitise();
    test_priority();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run time exceeded, got %0t want < 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/time_counter.md
# time_counter

Calendar/time-of-day counter that consumes the one-cycle `tick` pulse from the tick generator and advances seconds, minutes, hours, day, month, year and century. It is the receiving end of the tick interface and sits between the tick generator and the display/edit logic. It provides a synchronous load path for setting the time. Months have the correct lengths, and leap years follow the Gregorian rule for the full century count.

## Interface
- `RST_CENT`, 20: century value after reset (0..99).
- `RST_YEAR`, 0: year-in-century value after reset (0..99).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `tick`  in  1  advance-one-second strobe, one `clk` cycle wide.
- `load`  in  1  synchronous load of all `ld_*` fields.
- `ld_sec`  in  6  seconds to load.
- `ld_min`  in  6  minutes to load.
- `ld_hour`  in  5  hours to load.
- `ld_day`  in  5  day of month to load.
- `ld_mon`  in  4  month to load.
- `ld_year`  in  7  year in century to load.
- `ld_cent`  in  7  century to load.
- `sec`, `min`  out  6  current seconds and minutes, 0..59.
- `hour`  out  5  current hour, 0..23.
- `day`  out  5  current day of month, 1..28/29/30/31.
- `mon`  out  4  current month, 1..12.
- `year`, `cent`  out  7  current year in century and century, 0..99.
- `leap`  out  1  current year is a leap year (combinational from `year`/`cent`).
- `new_day`  out  1  one-cycle pulse on midnight rollover.
- `cent_wrap`  out  1  one-cycle pulse when the century count wraps from 99 to 0.

## Operation
- **Reset** (`rst`=0, async): `sec`=`min`=`hour`=0, `day`=1, `mon`=1, `year`=`RST_YEAR`, `cent`=`RST_CENT`, `new_day`=`cent_wrap`=0.
- **Priority:** `load` beats `tick` in the same cycle. On a load cycle the tick is dropped and does not count.
- **Tick cascade:** all in one cycle, no multi-cycle FSM.
  - `sec` increments. At 59 it goes to 0 and carries to `min`.
  - `min` 59 goes to 0 and carries to `hour`.
  - `hour` 23 goes to 0, carries to `day`, and pulses `new_day`.
  - `day` equal to the month length goes to 1 and carries to `mon`.
  - `mon` 12 goes to 1 and carries to `year`.
  - `year` 99 goes to 0 and carries to `cent`.
  - `cent` 99 goes to 0 and pulses `cent_wrap`.
- **Month length:**
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - Month 2 is 29 if `leap`, else 28.
- **Leap rule:** `leap` = (`year` mod 4 == 0) and (`year` != 0 or `cent` mod 4 == 0).
  - Year 2000 is leap; 2100 and 1900 are not.
  - Mod 4 is taken from the low two bits, so no divider is needed.
- **Load sanitisation:** applied before registering.
  - `ld_sec`/`ld_min` above 59 saturate to 59.
  - `ld_hour` above 23 saturates to 23.
  - `ld_mon` of 0 becomes 1; above 12 becomes 12.
  - `ld_year`/`ld_cent` above 99 saturate to 99.
  - `ld_day` of 0 becomes 1. Above the month length, it becomes that length, computed from the sanitised loaded month, year and century.
- A load never produces `new_day` or `cent_wrap` pulses.

## Timing
- Every output is registered except `leap`.
- A `tick` sampled high at edge N shows its updated fields after edge N, with zero added latency.
- `new_day` and `cent_wrap` are high for exactly the cycle after edge N.
- If `tick` is held high for k cycles, the counter advances k seconds. The upstream interface guarantees single-cycle pulses.
- Asserting `rst` mid-cascade forces reset values immediately. After deassertion the first counted tick is the first one sampled high.

## Test plan
- **Reset:** assert `rst`=0 with `tick` toggling. Required: 00:00:00, 01/01, `year`=0, `cent`=20, no pulses. Release `rst`, send 3 ticks. Required: `sec`=3.
- **Midnight rollover:** load 23:59:59 on 1/31, 2023 (cent 20, year 23), then tick once. Required: 00:00:00 on 2/1 and a one-cycle `new_day`.
- **Leap handling:**
  - Load 2024-02-28 23:59:59 and tick. Required: day 29.
  - Load 2100-02-28 23:59:59 and tick. Required: 3/1.
  - Load 2000-02-28 23:59:59 and tick. Required: day 29.
- **Century wrap:** load cent 99, year 99, 12/31 23:59:59, then tick. Required: all time fields 0, 01/01, year 0, cent 0, `cent_wrap` high for one cycle.
- **Load sanitisation and priority:**
  - Load sec 63, hour 30, mon 0, day 31. Required: 59, 23, 1, 31.
  - Load 2023, mon 4, day 31. Required: day 30.
  - Assert `load` and `tick` together. Required: loaded values, no increment.
- **Async reset mid-run:** pull `rst` low between clock edges while at 12:34:56. Required: outputs reach reset values before the next `clk` edge.
